// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access size codes,
// writeback bundle layout, FSM states and small helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    localparam int unsigned WB_W        = 71;
    localparam int unsigned WB_DATA_LSB = 0;
    localparam int unsigned WB_WE       = 32;
    localparam int unsigned WB_DEST_LSB = 33;
    localparam int unsigned WB_PC4_LSB  = 38;
    localparam int unsigned WB_VALID    = 70;

    // Half needs addr[0]=0; word (and the reserved code, treated as word)
    // needs addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lsb[0];
            default: mis = (lsb != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [WB_W-1:0] wb_pack(input logic        valid,
                                                input logic [31:0] pc4,
                                                input logic [4:0]  dest,
                                                input logic        we,
                                                input logic [31:0] data);
        logic [WB_W-1:0] wb;
        wb = '0;
        wb[WB_DATA_LSB +: 32] = data;
        wb[WB_WE]             = we;
        wb[WB_DEST_LSB +: 5]  = dest;
        wb[WB_PC4_LSB +: 32]  = pc4;
        wb[WB_VALID]          = valid;
        return wb;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the byte/half lane from the access offset
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lsb_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select and extension
    always_comb begin
        byte_v = rdata_i[{addr_lsb_i, 3'b000} +: 8];
        half_v = addr_lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = rdata_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack data-memory
// handshake, stalls upstream while an access is outstanding, aligns load
// data and builds the writeback bundle for the ME/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_we,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_pc4,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic [70:0] wb_out
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req_q, req_d;
    logic             dwe_q, dwe_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;

    logic             load_q, load_d;
    logic             we_q, we_d;
    logic [4:0]       dest_q, dest_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [1:0]       lsb_q, lsb_d;

    logic [31:0]      ld_data;
    logic [WB_W-1:0]  wb_c;

    load_align u_load_align (
        .rdata_i    (dmem_rdata),
        .addr_lsb_i (lsb_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    // State, request registers and latched access context
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            dwe_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            load_q  <= 1'b0;
            we_q    <= 1'b0;
            dest_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            pc4_q   <= '0;
            lsb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            dwe_q   <= dwe_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            load_q  <= load_d;
            we_q    <= we_d;
            dest_q  <= dest_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            pc4_q   <= pc4_d;
            lsb_q   <= lsb_d;
        end
    end

    // Next-state, request setup, stall and writeback bundle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        dwe_d   = dwe_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        load_d  = load_q;
        we_d    = we_q;
        dest_d  = dest_q;
        size_d  = size_q;
        uns_d   = uns_q;
        pc4_d   = pc4_q;
        lsb_d   = lsb_q;
        stall   = 1'b0;
        wb_c    = '0;

        // stall/wb_out are gated by reset so an abandoned access releases
        // upstream immediately, without waiting for a clock edge.
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (!(ex_mem_rd || ex_mem_wr)) begin
                            wb_c = wb_pack(1'b1, ex_pc4, ex_dest, ex_we, ex_alu_result);
                        end else if (is_misaligned(ex_size, ex_alu_result[1:0])) begin
                            mis_d = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = ST_WAIT;
                            cnt_d   = '0;
                            req_d   = 1'b1;
                            dwe_d   = ex_mem_wr;
                            addr_d  = {ex_alu_result[31:2], 2'b00};
                            load_d  = ex_mem_rd;
                            we_d    = ex_we;
                            dest_d  = ex_dest;
                            size_d  = ex_size;
                            uns_d   = ex_unsigned;
                            pc4_d   = ex_pc4;
                            lsb_d   = ex_alu_result[1:0];
                            if (ex_mem_wr) begin
                                case (ex_size)
                                    SZ_BYTE: begin
                                        be_d    = 4'b0001 << ex_alu_result[1:0];
                                        wdata_d = {4{ex_store_data[7:0]}};
                                    end
                                    SZ_HALF: begin
                                        be_d    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                                        wdata_d = {2{ex_store_data[15:0]}};
                                    end
                                    default: begin
                                        be_d    = 4'b1111;
                                        wdata_d = ex_store_data;
                                    end
                                endcase
                            end else begin
                                be_d    = 4'b1111;
                                wdata_d = '0;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    stall = 1'b1;
                    if (dmem_ack) begin
                        stall   = 1'b0;
                        wb_c    = wb_pack(1'b1, pc4_q, dest_q, load_q & we_q,
                                          load_q ? ld_data : 32'h0);
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        stall   = 1'b0;
                        berr_d  = 1'b1;
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = dwe_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;
    assign wb_out     = wb_c;

endmodule

// File: tb/tb_mem_stage.sv
// Directed test of mem_stage with TIMEOUT=4.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_pc4;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic [70:0] wb_out;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_we         (ex_we),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_pc4        (ex_pc4),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .misaligned    (misaligned),
        .bus_err       (bus_err),
        .wb_out        (wb_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] wb(input logic v, input logic [31:0] pc4,
                                       input logic [4:0] d, input logic we,
                                       input logic [31:0] data);
        return {v, pc4, d, we, data};
    endfunction

    task automatic drive_idle();
        ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_dest = 0;
        ex_we = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_size = 0;
        ex_unsigned = 0; ex_pc4 = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] dest,
                            input logic we, input logic [31:0] pc4);
        ex_valid = 1; ex_mem_rd = rd; ex_mem_wr = wr; ex_size = size;
        ex_unsigned = uns; ex_alu_result = addr; ex_store_data = sdata;
        ex_dest = dest; ex_we = we; ex_pc4 = pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // From the issue cycle through n_nack WAIT cycles without ack; returns
    // just after the edge that begins the ack cycle.
    task automatic begin_access(input string tag, input int n_nack);
        mid();
        check({tag, "_issue_stall"}, stall, 1'b1);
        check({tag, "_issue_wb"}, wb_out, '0);
        for (int i = 0; i < n_nack; i++) begin
            step();
            mid();
            check({tag, "_wait_req"}, dmem_req, 1'b1);
            check({tag, "_wait_stall"}, stall, 1'b1);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        mid();
        check("rst_req", dmem_req, 1'b0);
        check("rst_dmem", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, '0);
        check("rst_flags", {misaligned, bus_err, stall}, '0);
        check("rst_wb", wb_out, '0);
        step();
        rst = 1;

        // ALU op passes through combinationally; ack in IDLE is ignored
        drive_op(0, 0, 2'b10, 0, 32'hCAFE0001, 0, 5'd4, 1, 32'h10);
        dmem_ack = 1;
        #1;
        check("alu_wb", wb_out, wb(1, 32'h10, 5'd4, 1, 32'hCAFE0001));
        check("alu_stall", stall, 1'b0);
        step();
        mid();
        check("idle_ack_req", dmem_req, 1'b0);
        step();
        drive_idle();

        // Word load, ack two cycles after the request
        drive_op(1, 0, 2'b10, 0, 32'h100, 0, 5'd5, 1, 32'h404);
        begin_access("lw", 2);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_be_we", {dmem_be, dmem_we}, {4'b1111, 1'b0});
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        mid();
        check("lw_ack_stall", stall, 1'b0);
        check("lw_wb", wb_out, wb(1, 32'h404, 5'd5, 1, 32'hDEADBEEF));
        step();
        drive_idle();
        mid();
        check("lw_done_req", dmem_req, 1'b0);

        // lb then lbu at byte offset 3
        step();
        drive_op(1, 0, 2'b00, 0, 32'h203, 0, 5'd7, 1, 32'h208);
        begin_access("lb", 1);
        check("lb_addr", dmem_addr, 32'h200);
        dmem_ack = 1; dmem_rdata = 32'h80112233;
        mid();
        check("lb_wb", wb_out, wb(1, 32'h208, 5'd7, 1, 32'hFFFFFF80));
        step();
        drive_op(1, 0, 2'b00, 1, 32'h203, 0, 5'd7, 1, 32'h208);
        dmem_ack = 0;
        begin_access("lbu", 1);
        dmem_ack = 1; dmem_rdata = 32'h80112233;
        mid();
        check("lbu_wb", wb_out, wb(1, 32'h208, 5'd7, 1, 32'h00000080));
        step();
        drive_idle();

        // Signed half load from the upper lane
        drive_op(1, 0, 2'b01, 0, 32'h82, 0, 5'd8, 1, 32'h20);
        begin_access("lh", 0);
        dmem_ack = 1; dmem_rdata = 32'h9ABC0000;
        mid();
        check("lh_wb", wb_out, wb(1, 32'h20, 5'd8, 1, 32'hFFFF9ABC));
        step();
        drive_idle();

        // Half store at offset 2; ex_we set but writeback must not write
        drive_op(0, 1, 2'b01, 0, 32'h102, 32'h00001234, 5'd3, 1, 32'h50);
        begin_access("sh", 1);
        check("sh_addr", dmem_addr, 32'h100);
        check("sh_be", dmem_be, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'h12341234);
        check("sh_we", dmem_we, 1'b1);
        dmem_ack = 1;
        mid();
        check("sh_wb", wb_out, wb(1, 32'h50, 5'd3, 0, 32'h0));
        step();
        drive_idle();

        // Byte store at offset 1
        drive_op(0, 1, 2'b00, 0, 32'h001, 32'h000000AB, 5'd0, 0, 32'h60);
        begin_access("sb", 0);
        check("sb_be", dmem_be, 4'b0010);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        dmem_ack = 1;
        mid();
        check("sb_wb", wb_out, wb(1, 32'h60, 5'd0, 0, 32'h0));
        step();
        drive_idle();

        // Misaligned word load
        drive_op(1, 0, 2'b10, 0, 32'h101, 0, 5'd9, 1, 32'h70);
        mid();
        check("mis_stall", stall, 1'b0);
        check("mis_wb", wb_out, '0);
        step();
        drive_idle();
        mid();
        check("mis_pulse", misaligned, 1'b1);
        check("mis_req", dmem_req, 1'b0);
        step();
        mid();
        check("mis_pulse_end", misaligned, 1'b0);

        // Timeout: no ack for TIMEOUT cycles
        step();
        drive_op(1, 0, 2'b10, 0, 32'h300, 0, 5'd2, 1, 32'h80);
        mid();
        check("to_issue_stall", stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            check("to_req", dmem_req, 1'b1);
            check("to_stall", stall, (i < 3));
            check("to_berr_early", bus_err, 1'b0);
        end
        check("to_wb", wb_out, '0);
        step();
        drive_idle();
        mid();
        check("to_berr", bus_err, 1'b1);
        check("to_req_drop", dmem_req, 1'b0);
        step();
        mid();
        check("to_berr_end", bus_err, 1'b0);

        // Ack in the last WAIT cycle beats the timeout
        step();
        drive_op(1, 0, 2'b10, 0, 32'h304, 0, 5'd6, 1, 32'h90);
        begin_access("toack", 3);
        dmem_ack = 1; dmem_rdata = 32'h11223344;
        mid();
        check("toack_stall", stall, 1'b0);
        check("toack_wb", wb_out, wb(1, 32'h90, 5'd6, 1, 32'h11223344));
        step();
        drive_idle();
        mid();
        check("toack_berr", bus_err, 1'b0);
        check("toack_req", dmem_req, 1'b0);

        // Asynchronous reset in the middle of WAIT
        step();
        drive_op(1, 0, 2'b10, 0, 32'h400, 0, 5'd1, 1, 32'hA0);
        step();
        mid();
        check("rw_req_before", dmem_req, 1'b1);
        #2;
        rst = 0;
        #1;
        check("rw_req_async", dmem_req, 1'b0);
        check("rw_stall_async", stall, 1'b0);
        check("rw_wb_async", wb_out, '0);
        step();
        check("rw_req_held", dmem_req, 1'b0);
        rst = 1;
        drive_op(0, 0, 2'b00, 0, 32'h12345678, 0, 5'd9, 1, 32'h1000);
        #1;
        check("rw_alu_wb", wb_out, wb(1, 32'h1000, 5'd9, 1, 32'h12345678));
        check("rw_alu_stall", stall, 1'b0);
        mid();
        check("rw_alu_req", dmem_req, 1'b0);

        step();
        drive_idle();
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/ME pipeline register and the ME/WB register.
- Takes the EX result bundle and performs loads and stores on the data memory through a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding, aligns and extends load data, and produces the 71-bit writeback bundle that the ME/WB register latches.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without dmem_ack before the access is abandoned (>=2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/ME slot holds a real instruction.
- ex_alu_result  in  32  ALU result; this is the effective address for memory ops.
- ex_store_data  in  32  rt value for stores.
- ex_dest  in  5  destination register.
- ex_we  in  1  register write enable.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store. ex_mem_rd and ex_mem_wr are never both 1.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ex_unsigned  in  1  zero-extend the load (lbu/lhu).
- ex_pc4  in  32  PC+4, carried to writeback.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata  in  32  read data.
- stall  out  1  hold EX/ME and all earlier stages.
- misaligned  out  1  one-cycle pulse on an unaligned access.
- bus_err  out  1  one-cycle pulse on timeout.
- wb_out  out  71  bundle to ME/WB: [31:0] data, [32] we, [37:33] dest, [69:38] pc4, [70] valid.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, counter 0, and every registered output is 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, misaligned, bus_err).
- Reset mid-access: the access is dropped immediately (dmem_req falls) with no writeback.
- States: IDLE and WAIT.
- IDLE, non-memory op (ex_valid=1, rd=wr=0):
  - wb_out is combinational from the inputs: data=ex_alu_result, we=ex_we, valid=1.
  - stall=0.
  - Zero added latency; ME/WB captures it on the same edge.
- IDLE, ex_valid=0: wb_out is all zeros, a bubble.
- IDLE, memory op, misaligned:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued and stall=0.
  - wb_out is a bubble (valid=0, we=0).
  - misaligned pulses on the next cycle.
- IDLE, memory op, aligned:
  - stall=1 and wb_out is a bubble.
  - At the edge: latch dest/we/size/unsigned/pc4/addr[1:0], drive the dmem_* registers, set dmem_req=1, clear the counter, and go to WAIT.
- WAIT: stall=1 and dmem_req=1, with all dmem_* outputs held stable. The counter increments each cycle without ack.
  - dmem_ack=1:
    - stall=0 in this same cycle.
    - wb_out valid=1, carrying the latched dest and pc4.
    - Load: we = latched ex_we, data = aligned load.
    - Store: we=0, data=0.
    - At the edge: dmem_req=0 and go to IDLE.
    - Upstream advances on this edge, so a new op is seen in IDLE the following cycle. This gives back-to-back accesses a one-cycle gap.
  - No ack and counter==TIMEOUT-1:
    - stall=0 and wb_out is a bubble.
    - At the edge: bus_err pulses, dmem_req=0, go to IDLE.
  - Ack in the same cycle as timeout: the ack wins, and bus_err stays 0.
- Store lanes, with k=addr[1:0]:
  - Byte: be = 1<<k, wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
- Load lanes:
  - Loads drive be = 1111.
  - Select the byte or half lane from the latched addr[1:0].
  - Sign-extend unless the unsigned flag is set; then zero-extend.
- dmem_ack is ignored in IDLE.

Decomposition:
- Package mem_pkg holds:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - WB_W=71;
  - the field offsets WB_DATA_LSB=0, WB_WE=32, WB_DEST_LSB=33, WB_PC4_LSB=38, WB_VALID=70.
- Sub-module load_align: combinational, takes (rdata, addr[1:0], size, unsigned) and returns data[31:0].
- Store lane/byte-enable generation stays inline.

Test Plan:
- Word load: addr 0x100, ack 2 cycles after the request, rdata 0xDEADBEEF.
  - stall is high for 3 cycles.
  - In the ack cycle, wb_out data=0xDEADBEEF, we=1, valid=1.
- Signed byte load (lb): addr 0x203, rdata 0x80112233 → data 0xFFFFFF80. The same access as lbu → 0x00000080.
- Half store: addr 0x102, store_data 0x00001234 → dmem_be=1100, dmem_wdata=0x12341234, dmem_we=1. In the ack cycle, wb_out we=0.
- Misaligned word load: addr 0x101.
  - No dmem_req and stall stays 0.
  - misaligned pulses once and wb_out valid=0.
- Timeout: TIMEOUT=4, no ack.
  - dmem_req is high for exactly 4 cycles.
  - bus_err pulses once, then IDLE.
  - Repeat with ack arriving in the 4th WAIT cycle: bus_err=0 and valid writeback.
- Reset mid-WAIT: rst driven low asynchronously.
  - dmem_req and stall drop without waiting for a clock edge.
  - No wb_out valid.
  - After release, an ALU op passes through in 0 cycles.
